trace_axis_lane_packer: RTL

// - Sits directly downstream of the trace AXI-stream source (96-bit {pc, instr} beats) and upstream of the AXI DMA S2MM port.
// - Repacks IN_LANES x 32-bit input beats into OUT_LANES x 32-bit output words, lossless and in order.
// - Tags the final word of each packet with tlast and zero-pads a partial final word.
// - Keeps beat/word/packet counters for software.

---
 rtl/trace_pkg.sv | 10 +
 rtl/trace_lane_shift_buffer.sv | 67 ++++++
 rtl/trace_axis_lane_packer.sv | 90 +++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared trace-path constants and the lane type used by the trace source and the DMA packer.
package trace_pkg;
    localparam int LANE_WIDTH       = 32;
    localparam int TRACE_BEAT_LANES = 3;
    localparam int DMA_WORD_LANES   = 2;

    typedef logic [LANE_WIDTH-1:0] lane_t;

    localparam lane_t WFI_INSTRUCTION = 32'h1050_0073;
endpackage

// File: rtl/trace_lane_shift_buffer.sv
// Lane buffer with pop-then-push update: pops shift down by OUT_LANES, pushes append above the count.
module trace_lane_shift_buffer #(
    parameter int LANE_WIDTH = 32,
    parameter int IN_LANES   = 3,
    parameter int OUT_LANES  = 2,
    parameter int BUF_LANES  = IN_LANES + OUT_LANES,
    parameter int CW         = $clog2(BUF_LANES + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pop,
    input  logic                            push,
    input  logic [IN_LANES*LANE_WIDTH-1:0]  push_data,
    output logic [OUT_LANES*LANE_WIDTH-1:0] head,
    output logic [CW-1:0]                   count
);
    typedef logic [LANE_WIDTH-1:0] lane_w_t;

    lane_w_t       lane_q   [BUF_LANES];
    lane_w_t       lane_d   [BUF_LANES];
    lane_w_t       lane_ext [BUF_LANES+OUT_LANES];
    logic [CW-1:0] base;
    logic [CW-1:0] count_d;

    always_comb begin
        // zero-extended view so the shift never indexes past the buffer
        lane_ext = '{default: '0};
        for (int i = 0; i < BUF_LANES; i++) begin
            lane_ext[i] = lane_q[i];
        end

        lane_d = lane_q;
        base   = count;
        if (pop) begin
            for (int i = 0; i < BUF_LANES; i++) begin
                lane_d[i] = lane_ext[i+OUT_LANES];
            end
            base = (count > CW'(OUT_LANES)) ? count - CW'(OUT_LANES) : '0;
        end

        count_d = base;
        if (push) begin
            for (int i = 0; i < BUF_LANES; i++) begin
                for (int k = 0; k < IN_LANES; k++) begin
                    if (i == int'(base) + k) begin
                        lane_d[i] = push_data[k*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
            count_d = base + CW'(IN_LANES);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            lane_q <= '{default: '0};
        end else begin
            count  <= count_d;
            lane_q <= lane_d;
        end
    end

    for (genvar j = 0; j < OUT_LANES; j++) begin : g_head
        assign head[j*LANE_WIDTH +: LANE_WIDTH] = lane_q[j];
    end
endmodule

// File: rtl/trace_axis_lane_packer.sv
// Repacks trace beats into DMA words, tags/pads packet ends and keeps beat/word/packet statistics.
module trace_axis_lane_packer #(
    parameter int                  LANE_WIDTH = trace_pkg::LANE_WIDTH,
    parameter int                  IN_LANES   = trace_pkg::TRACE_BEAT_LANES,
    parameter int                  OUT_LANES  = trace_pkg::DMA_WORD_LANES,
    parameter logic [LANE_WIDTH-1:0] PAD_LANE = '0,
    parameter int                  CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            S_AXIS_tvalid,
    output logic                            S_AXIS_tready,
    input  logic [IN_LANES*LANE_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                            S_AXIS_tlast,
    output logic                            M_AXIS_tvalid,
    input  logic                            M_AXIS_tready,
    output logic [OUT_LANES*LANE_WIDTH-1:0] M_AXIS_tdata,
    output logic                            M_AXIS_tlast,
    input  logic                            clr_counters,
    output logic [CNT_WIDTH-1:0]            beats_in,
    output logic [CNT_WIDTH-1:0]            words_out,
    output logic [CNT_WIDTH-1:0]            packets_out
);
    localparam int BUF_LANES = IN_LANES + OUT_LANES;
    localparam int CW        = $clog2(BUF_LANES + 1);

    if (IN_LANES < 1 || OUT_LANES < 1) begin : g_bad_params
        $error("trace_axis_lane_packer: IN_LANES and OUT_LANES must both be >= 1");
    end

    logic [CW-1:0]                   count;
    logic [OUT_LANES*LANE_WIDTH-1:0] head;
    logic                            last_flag;
    logic                            push;
    logic                            pop;

    // a full beat must fit above whatever survives; packet ends block new input until drained
    assign S_AXIS_tready = rst_n & ~last_flag & (count <= CW'(BUF_LANES - IN_LANES));
    assign M_AXIS_tvalid = rst_n & ((count >= CW'(OUT_LANES)) | (last_flag & (count != '0)));
    assign M_AXIS_tlast  = rst_n & last_flag & (count <= CW'(OUT_LANES));

    for (genvar j = 0; j < OUT_LANES; j++) begin : g_out
        assign M_AXIS_tdata[j*LANE_WIDTH +: LANE_WIDTH] =
            (CW'(j) < count) ? head[j*LANE_WIDTH +: LANE_WIDTH] : PAD_LANE;
    end

    assign push = S_AXIS_tvalid & S_AXIS_tready;
    assign pop  = M_AXIS_tvalid & M_AXIS_tready;

    trace_lane_shift_buffer #(
        .LANE_WIDTH (LANE_WIDTH),
        .IN_LANES   (IN_LANES),
        .OUT_LANES  (OUT_LANES),
        .BUF_LANES  (BUF_LANES),
        .CW         (CW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .pop       (pop),
        .push      (push),
        .push_data (S_AXIS_tdata),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_flag   <= 1'b0;
            beats_in    <= '0;
            words_out   <= '0;
            packets_out <= '0;
        end else begin
            if (push && S_AXIS_tlast) begin
                last_flag <= 1'b1;
            end else if (pop && M_AXIS_tlast) begin
                last_flag <= 1'b0;
            end

            if (clr_counters) begin
                beats_in    <= '0;
                words_out   <= '0;
                packets_out <= '0;
            end else begin
                if (push)                 beats_in    <= beats_in + CNT_WIDTH'(1);
                if (pop)                  words_out   <= words_out + CNT_WIDTH'(1);
                if (pop && M_AXIS_tlast)  packets_out <= packets_out + CNT_WIDTH'(1);
            end
        end
    end
endmodule
